// File: rtl/pe_array_ctrl_if.sv
// Bundle of the tile-scheduler handshake, operand SRAM read port, PE array
// control/lane signals and output SRAM write port of the PE array sequencer.
interface pe_array_ctrl_if #(
  parameter int OPND_BWIDTH            = 8,
  parameter int PE_ARRAY_NUM_ROWS      = 32,
  parameter int PE_ARRAY_NUM_ROWS_LOG2 = 5,
  parameter int PE_ARRAY_NUM_COLS      = 32,
  parameter int K_LEN_BWIDTH           = 10
) ();
  logic                                        STALL;
  logic                                        START_in;
  logic [K_LEN_BWIDTH-1:0]                     K_LEN_in;
  logic                                        BUSY_out;
  logic                                        DONE_out;
  logic                                        OPND_RD_EN_out;
  logic [K_LEN_BWIDTH-1:0]                     OPND_RD_ADDR_out;
  logic [PE_ARRAY_NUM_ROWS*OPND_BWIDTH-1:0]    OPND1_SRAM_DATA_in;
  logic [PE_ARRAY_NUM_COLS*OPND_BWIDTH-1:0]    OPND2_SRAM_DATA_in;
  logic                                        ARRAY_STALL_out;
  logic                                        IS_COMPUTING_out;
  logic                                        IS_FLUSHING_out;
  logic [PE_ARRAY_NUM_ROWS-1:0]                OPND1_IS_VALID_out;
  logic [PE_ARRAY_NUM_COLS-1:0]                OPND2_IS_VALID_out;
  logic [PE_ARRAY_NUM_ROWS*OPND_BWIDTH-1:0]    OPND1_DATA_out;
  logic [PE_ARRAY_NUM_COLS*OPND_BWIDTH-1:0]    OPND2_DATA_out;
  logic                                        OUT_WE_out;
  logic [PE_ARRAY_NUM_ROWS_LOG2-1:0]           OUT_ADDR_out;

  // Sequencer side
  modport slave (
    input  STALL, START_in, K_LEN_in, OPND1_SRAM_DATA_in, OPND2_SRAM_DATA_in,
    output BUSY_out, DONE_out, OPND_RD_EN_out, OPND_RD_ADDR_out, ARRAY_STALL_out,
           IS_COMPUTING_out, IS_FLUSHING_out, OPND1_IS_VALID_out, OPND2_IS_VALID_out,
           OPND1_DATA_out, OPND2_DATA_out, OUT_WE_out, OUT_ADDR_out
  );

  // Scheduler / array / SRAM side
  modport master (
    output STALL, START_in, K_LEN_in, OPND1_SRAM_DATA_in, OPND2_SRAM_DATA_in,
    input  BUSY_out, DONE_out, OPND_RD_EN_out, OPND_RD_ADDR_out, ARRAY_STALL_out,
           IS_COMPUTING_out, IS_FLUSHING_out, OPND1_IS_VALID_out, OPND2_IS_VALID_out,
           OPND1_DATA_out, OPND2_DATA_out, OUT_WE_out, OUT_ADDR_out
  );
endinterface

// File: rtl/pe_array_ctrl.sv
// Sequencer for one output tile of the systolic PE array: reads K operand
// rows, skews them per lane into the array, runs COMPUTE/FLUSH phases and
// drains the accumulators bottom row first into the output SRAM.
module pe_array_ctrl #(
  parameter int OPND_BWIDTH            = 8,
  parameter int PE_ARRAY_NUM_ROWS      = 32,
  parameter int PE_ARRAY_NUM_ROWS_LOG2 = 5,
  parameter int PE_ARRAY_NUM_COLS      = 32,
  parameter int K_LEN_BWIDTH           = 10
) (
  input  logic           CLK,
  input  logic           RST,
  pe_array_ctrl_if.slave bus
);
  localparam int R    = PE_ARRAY_NUM_ROWS;
  localparam int C    = PE_ARRAY_NUM_COLS;
  localparam int W    = OPND_BWIDTH;
  localparam int KW   = K_LEN_BWIDTH;
  localparam int RL   = PE_ARRAY_NUM_ROWS_LOG2;
  localparam int PH_W = $clog2(R + C + 1);
  localparam int MAXL = (R > C) ? R : C;
  localparam int MAXD = (MAXL > 1) ? MAXL - 1 : 1;

  localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'(R + C - 2);
  localparam logic [PH_W-1:0] FLUSH_LAST = PH_W'(R);
  localparam logic [RL-1:0]   ROW_TOP    = RL'(R - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_FLUSH, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   k_len, k_len_nxt;
  logic [KW-1:0]   ld_cnt, ld_cnt_nxt;
  logic [PH_W-1:0] ph_cnt, ph_cnt_nxt;

  logic            rd_en;
  logic            rd_q_p0;
  logic            cap_vld_p0;
  logic [R*W-1:0]  cap1_p0;
  logic [C*W-1:0]  cap2_p0;
  logic [R*W-1:0]  lane1_p0;
  logic [C*W-1:0]  lane2_p0;
  logic [MAXD-1:0] vld_sh_p1;

  logic [W-1:0]    d1_lane [R];
  logic [W-1:0]    d2_lane [C];
  logic            v1_lane [R];
  logic            v2_lane [C];

  logic [RL-1:0]   flush_row;

  // FSM state, latched reduction length and phase counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      k_len  <= '0;
      ld_cnt <= '0;
      ph_cnt <= '0;
    end else begin
      state  <= state_nxt;
      k_len  <= k_len_nxt;
      ld_cnt <= ld_cnt_nxt;
      ph_cnt <= ph_cnt_nxt;
    end
  end

  // Next-state and counter sequencing; a stall freezes everything
  always_comb begin
    state_nxt  = state;
    k_len_nxt  = k_len;
    ld_cnt_nxt = ld_cnt;
    ph_cnt_nxt = ph_cnt;
    if (!bus.STALL) begin
      case (state)
        S_IDLE: begin
          if (bus.START_in) begin
            k_len_nxt  = bus.K_LEN_in;
            ld_cnt_nxt = '0;
            ph_cnt_nxt = '0;
            state_nxt  = (bus.K_LEN_in == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (ld_cnt == k_len - 1'b1) begin
            state_nxt  = S_DRAIN;
            ph_cnt_nxt = '0;
          end else begin
            ld_cnt_nxt = ld_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (ph_cnt == DRAIN_LAST) begin
            state_nxt  = S_FLUSH;
            ph_cnt_nxt = '0;
          end else begin
            ph_cnt_nxt = ph_cnt + 1'b1;
          end
        end
        S_FLUSH: begin
          if (ph_cnt == FLUSH_LAST) begin
            state_nxt = S_DONE;
          end else begin
            ph_cnt_nxt = ph_cnt + 1'b1;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign rd_en     = (state == S_LOAD) && !bus.STALL;
  // First flush cycle (ph_cnt 0) has no write; rows R-1..0 follow
  assign flush_row = ROW_TOP - (ph_cnt[RL-1:0] - 1'b1);

  assign bus.ARRAY_STALL_out  = bus.STALL;
  assign bus.BUSY_out         = (state != S_IDLE);
  assign bus.DONE_out         = (state == S_DONE);
  assign bus.OPND_RD_EN_out   = rd_en;
  assign bus.OPND_RD_ADDR_out = (state == S_LOAD) ? ld_cnt : '0;
  assign bus.IS_COMPUTING_out = (state == S_LOAD) || (state == S_DRAIN);
  assign bus.IS_FLUSHING_out  = (state == S_FLUSH);
  assign bus.OUT_WE_out       = (state == S_FLUSH) && (ph_cnt != '0) && !bus.STALL;
  assign bus.OUT_ADDR_out     = ((state == S_FLUSH) && (ph_cnt != '0)) ? flush_row : '0;

  // ---- capture stage p0: SRAM data is live the cycle after a read and is
  // held locally so a stall landing on that cycle does not lose it
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_q_p0    <= 1'b0;
      cap_vld_p0 <= 1'b0;
      cap1_p0    <= '0;
      cap2_p0    <= '0;
    end else begin
      rd_q_p0 <= rd_en;
      if (rd_q_p0) begin
        cap1_p0 <= bus.OPND1_SRAM_DATA_in;
        cap2_p0 <= bus.OPND2_SRAM_DATA_in;
      end
      if (!bus.STALL) cap_vld_p0 <= rd_en;
    end
  end

  assign lane1_p0 = cap_vld_p0 ? (rd_q_p0 ? bus.OPND1_SRAM_DATA_in : cap1_p0) : '0;
  assign lane2_p0 = cap_vld_p0 ? (rd_q_p0 ? bus.OPND2_SRAM_DATA_in : cap2_p0) : '0;

  // ---- skew stages p1..: shared valid delay line, frozen by stall
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_sh_p1 <= '0;
    end else if (!bus.STALL) begin
      vld_sh_p1[0] <= cap_vld_p0;
      for (int i = 1; i < MAXD; i++) vld_sh_p1[i] <= vld_sh_p1[i-1];
    end
  end

  for (genvar r = 0; r < R; r++) begin : g_opnd1
    if (r == 0) begin : g_direct
      assign d1_lane[0] = lane1_p0[W-1:0];
      assign v1_lane[0] = cap_vld_p0;
    end else begin : g_skew
      logic [W-1:0] pipe_p1 [r];
      // Row r lane delayed r cycles behind the capture stage
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int d = 0; d < r; d++) pipe_p1[d] <= '0;
        end else if (!bus.STALL) begin
          pipe_p1[0] <= lane1_p0[r*W +: W];
          for (int d = 1; d < r; d++) pipe_p1[d] <= pipe_p1[d-1];
        end
      end
      assign d1_lane[r] = pipe_p1[r-1];
      assign v1_lane[r] = vld_sh_p1[r-1];
    end
  end

  for (genvar c = 0; c < C; c++) begin : g_opnd2
    if (c == 0) begin : g_direct
      assign d2_lane[0] = lane2_p0[W-1:0];
      assign v2_lane[0] = cap_vld_p0;
    end else begin : g_skew
      logic [W-1:0] pipe_p1 [c];
      // Column c lane delayed c cycles behind the capture stage
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int d = 0; d < c; d++) pipe_p1[d] <= '0;
        end else if (!bus.STALL) begin
          pipe_p1[0] <= lane2_p0[c*W +: W];
          for (int d = 1; d < c; d++) pipe_p1[d] <= pipe_p1[d-1];
        end
      end
      assign d2_lane[c] = pipe_p1[c-1];
      assign v2_lane[c] = vld_sh_p1[c-1];
    end
  end

  // Pack the per-lane skew outputs onto the array buses
  always_comb begin
    bus.OPND1_DATA_out     = '0;
    bus.OPND1_IS_VALID_out = '0;
    bus.OPND2_DATA_out     = '0;
    bus.OPND2_IS_VALID_out = '0;
    for (int r = 0; r < R; r++) begin
      bus.OPND1_DATA_out[r*W +: W] = d1_lane[r];
      bus.OPND1_IS_VALID_out[r]    = v1_lane[r];
    end
    for (int c = 0; c < C; c++) begin
      bus.OPND2_DATA_out[c*W +: W] = d2_lane[c];
      bus.OPND2_IS_VALID_out[c]    = v2_lane[c];
    end
  end

endmodule

// File: doc/pe_array_ctrl.md
Name: pe_array_ctrl

Overview:
Sequencer for one output tile of the systolic PE array. It reads K operand rows from the OPND1/OPND2 SRAMs and applies the per-lane input skew. It generates the valid masks and the COMPUTE/FLUSH phases, then drains the accumulators row by row into the output SRAM. It sits between the tile scheduler (START/DONE) and the PE array plus its SRAMs.

Parameters:
OPND_BWIDTH, 8, operand width (INT8)
PE_ARRAY_NUM_ROWS, 32, PE array rows (R)
PE_ARRAY_NUM_ROWS_LOG2, 5, log2(R)
PE_ARRAY_NUM_COLS, 32, PE array cols (C)
K_LEN_BWIDTH, 10, width of the reduction length and of the SRAM read address

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
STALL  in  1  global stall
START_in  in  1  start-tile pulse
K_LEN_in  in  K_LEN_BWIDTH  reduction length, sampled with START_in
BUSY_out  out  1  tile in progress
DONE_out  out  1  one-cycle completion pulse
OPND_RD_EN_out  out  1  read enable, shared by both operand SRAMs
OPND_RD_ADDR_out  out  K_LEN_BWIDTH  read row address
OPND1_SRAM_DATA_in  in  R*OPND_BWIDTH  OPND1 SRAM read data, 1-cycle latency
OPND2_SRAM_DATA_in  in  C*OPND_BWIDTH  OPND2 SRAM read data, 1-cycle latency
ARRAY_STALL_out  out  1  stall to array, equals STALL
IS_COMPUTING_out  out  1  array compute enable
IS_FLUSHING_out  out  1  array flush enable
OPND1_IS_VALID_out  out  R  skewed per-row valid
OPND2_IS_VALID_out  out  C  skewed per-col valid
OPND1_DATA_out  out  R*OPND_BWIDTH  skewed OPND1 lanes
OPND2_DATA_out  out  C*OPND_BWIDTH  skewed OPND2 lanes
OUT_WE_out  out  1  output SRAM write enable
OUT_ADDR_out  out  PE_ARRAY_NUM_ROWS_LOG2  output SRAM row address

Behaviour:
- Clock and reset: one clock CLK. RST is synchronous and active-high.
- Reset: FSM goes to IDLE and all counters and skew registers clear. Every output is 0 except ARRAY_STALL_out, which is always STALL. A reset mid-tile aborts the tile with no DONE_out pulse.
- FSM states: IDLE, LOAD, DRAIN, FLUSH, DONE.
- IDLE: START_in=1 latches K_LEN_in.
  - K_LEN=0 goes directly to DONE.
  - Otherwise go to LOAD.
  - START_in in any other state is ignored.
- Cycle numbering: START_in is sampled in cycle c0.
- LOAD (K cycles, c1..cK):
  - OPND_RD_EN_out=1.
  - OPND_RD_ADDR_out=0..K-1.
- Capture stage:
  - Operand data is registered one cycle after each read, giving base valid v0 in c2..cK+1.
  - The capture register loads whenever a read was issued in the previous cycle, even if STALL=1.
- Skew:
  - OPND1 lane r and its OPND1_IS_VALID_out[r] = capture stage delayed r cycles.
  - OPND2 lane c and its OPND2_IS_VALID_out[c] = capture stage delayed c cycles.
  - Lane 0 has no extra delay. Invalid lanes drive data 0.
- DRAIN (R+C-1 cycles, cK+1..cK+R+C-1):
  - No reads.
  - The skew pipeline empties.
- IS_COMPUTING_out=1 in LOAD and DRAIN.
- FLUSH (R+1 cycles):
  - IS_FLUSHING_out=1 for the whole state.
  - OUT_WE_out=1 in the last R cycles of FLUSH.
  - OUT_ADDR_out = R-1 down to 0; the bottom row exits first.
- DONE: DONE_out=1 for one cycle, then IDLE.
- BUSY_out=1 in every state except IDLE.
- STALL=1 freezes the FSM, counters and skew pipeline.
  - OPND_RD_EN_out and OUT_WE_out are forced to 0.
  - IS_COMPUTING_out and IS_FLUSHING_out hold their values.
  - Operation resumes exactly where it stopped, and read addresses are never skipped or repeated.
- Counters: the LOAD counter is K_LEN_BWIDTH wide. The DRAIN/FLUSH counter is sized for R+C. No counter wraps.

Test Plan:
- R=C=4, K=3, START at c0:
  - RD_EN in c1..c3 with addresses 0,1,2.
  - OPND1_IS_VALID[3] and OPND2_IS_VALID[3] high in c5..c7.
  - IS_COMPUTING in c1..c10, IS_FLUSHING in c11..c15.
  - OUT_WE in c12..c15 with OUT_ADDR 3,2,1,0.
  - DONE at c16, BUSY in c1..c16.
- Skew data, R=C=4, K=1, OPND1 SRAM row 0 = lanes {0x11,0x22,0x33,0x44}: OPND1_DATA_out lane r shows its byte only in cycle c2+r, and 0 otherwise.
- K_LEN=0: BUSY and DONE both high at c1. No RD_EN, IS_COMPUTING or OUT_WE. Back in IDLE at c2.
- STALL held for 2 cycles in c2..c3 with K=3:
  - RD_EN is 0 during the stall, and address 1 is issued in c4.
  - Every later event in the K=3 trace shifts by exactly 2 cycles, and no address repeats.
- START_in pulsed at c5 during a tile: ignored, and the timing matches the K=3 trace exactly.
- RST at c8 mid-DRAIN: at c9 all outputs are 0 and the FSM is in IDLE with no DONE. A new START at c10 runs a clean K=3 trace.
